systolic_pe: RTL and testbench
==============================

# systolic_pe

Parametrised processing element for the weight-streaming systolic array. It is the successor of the fixed 8/16-bit MAC PE. It forwards A rightward and B downward with a valid qualifier, and accumulates signed or unsigned products per tile. It also drains finished results down a per-column shift chain while the next tile accumulates. One instance sits at every row/column intersection. Result chains are read out at the bottom of each column.

## Interface
- DATA_WIDTH, 8, operand width for A and B
- ACC_WIDTH, 24, accumulator width; must be ≥ 2*DATA_WIDTH (elaboration error otherwise)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- valid_in  in  1  A/B beat valid
- clear_in  in  1  first beat of a new tile; qualified by valid_in
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled per beat
- a_in  in  DATA_WIDTH  operand from the left
- b_in  in  DATA_WIDTH  operand from above
- drain_in  in  1  snapshot the current tile result into the chain
- c_in  in  ACC_WIDTH  chain data from the PE above (tie 0 at the top row)
- c_valid_in  in  1  chain valid from above (tie 0 at the top row)
- c_ovf_in  in  1  chain overflow flag from above
- a_out  out  DATA_WIDTH  registered A to the right
- b_out  out  DATA_WIDTH  registered B downward
- valid_out, clear_out, signed_out  out  1 each  registered copies of the beat qualifiers
- c_out  out  ACC_WIDTH  chain data downward
- c_valid_out  out  1  chain valid
- c_ovf_out  out  1  overflow flag travelling with c_out

## Operation
- **Forwarding**
  - When valid_in = 1: a/b/clear/signed registers load and valid_out <= 1.
  - Otherwise valid_out <= 0 and the a/b registers hold their value.
- **Product**
  - Width is 2*DATA_WIDTH.
  - Signed mode: sign-extended to ACC_WIDTH. Unsigned mode: zero-extended.
- **Accumulate** (a beat is cycles with valid_in = 1)
  - clear_in = 1: acc <= product.
  - clear_in = 0: acc <= acc + product.
  - clear_in without valid_in is ignored.
- **Overflow**
  - Sticky ovf sets when the addition leaves the signed or unsigned ACC_WIDTH range.
  - Cleared whenever acc is re-seeded (clear beat or drain).
- **FSM states**
  - ACC (reset state): drain_in = 1 takes the snapshot, then moves to DRAIN.
  - DRAIN: each cycle c_out <= c_in, c_valid_out <= c_valid_in, c_ovf_out <= c_ovf_in.
  - DRAIN exits to ACC on the cycle c_valid_in = 0. The invalid word is still shifted in.
  - drain_in while in DRAIN is ignored.
- **Snapshot**
  - c_out <= old-tile value, c_valid_out <= 1, c_ovf_out <= old-tile ovf.
  - Old-tile value = acc + (valid_in & !clear_in ? product : 0).
  - acc afterwards = (valid_in & clear_in) ? product : 0.
  - Overlapping a drain with the first beat of the next tile is therefore lossless.
- Accumulation continues in DRAIN. acc and the chain register are independent.
- All drain_in signals in a column are asserted in the same cycle. The bottom PE then emits N results on consecutive cycles, own result first, followed by one invalid cycle.

## Timing
- Reset: all outputs 0, acc 0, ovf 0, state ACC. Reset mid-drain aborts the chain with no partial output.
- Forwarding latency is 1 cycle. The acc update is visible 1 cycle after its beat.
- The snapshot appears on c_out 1 cycle after drain_in. Row k from the bottom (0-based) appears at the bottom after k+1 cycles.
- There is no backpressure. The consumer at the bottom of the column must accept one word per cycle.

## Configuration
- PE_SATURATE_EN defined:
  - On overflow, acc clamps to the max or min of the active mode. Unsigned: 2^ACC_WIDTH−1 or 0. Signed: 2^(ACC_WIDTH−1)−1 or −2^(ACC_WIDTH−1).
  - The clamped value persists under further same-direction beats.
- PE_SATURATE_EN undefined: acc wraps modulo 2^ACC_WIDTH.
- ovf is set in both builds.

## Structure
- Package pe_pkg holds:
  - default DATA_WIDTH/ACC_WIDTH localparams
  - the FSM state enum (PE_ACC, PE_DRAIN)
  - signed/unsigned min/max helper functions
- Sub-module pe_mac: combinational extend, multiply, add, overflow detect and optional saturation. Output is the next acc value and ovf.
- systolic_pe owns all registers and the FSM.

## Test plan
- Unsigned dot product: 4 beats of a=3, b=5, clear on beat 0; then drain → c_out=60, c_valid_out=1 one cycle later, ovf=0.
- Signed product: signed_mode=1, 2 beats of a=0xFE, b=3, ACC_WIDTH=16 → drained c_out=0xFFF4 (−12).
- Column chain: 3 stacked PEs hold acc 1, 2, 3 (top to bottom), common drain → bottom c_out 3, 2, 1 on consecutive cycles, then c_valid_out=0, and all PEs return to ACC.
- Overflow: ACC_WIDTH=16, unsigned, 2 beats of 255×255 → saturated build gives 0xFFFF; wrap build gives 64514; c_ovf_out=1 in both.
- Overlap: acc=60, then drain_in+valid_in+clear_in with a=2, b=4 in the same cycle → c_out=60, and the next tile's acc=8.
- Reset mid-drain: rst_n low during the second drain cycle → all outputs 0 immediately; after release, state is ACC and drain_in works normally.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared defaults, FSM state type and saturation limit helpers for the systolic PE.
// Limits are returned 64 bits wide; callers size-cast to their accumulator width.
package pe_pkg;

  localparam int PE_DATA_WIDTH = 8;
  localparam int PE_ACC_WIDTH  = 24;

  typedef enum logic {
    PE_ACC   = 1'b0,
    PE_DRAIN = 1'b1
  } pe_state_t;

  function automatic logic [63:0] pe_max(input int width, input logic sgn);
    logic [63:0] ones;
    ones = '1;
    return sgn ? (ones >> (65 - width)) : (ones >> (64 - width));
  endfunction

  function automatic logic [63:0] pe_min(input int width, input logic sgn);
    logic [63:0] one;
    one = 64'd1;
    return sgn ? (one << (width - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational extend/multiply/add with overflow detect; clamps when PE_SATURATE_EN is defined.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int ACC_WIDTH  = PE_ACC_WIDTH
) (
  input  logic                  signed_mode,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [ACC_WIDTH-1:0]  acc,
  output logic [ACC_WIDTH-1:0]  acc_nxt,
  output logic                  ovf
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        a_ext;
  logic [PW-1:0]        b_ext;
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf_u;
  logic                 ovf_s;

  always_comb begin
    // Low 2*DATA_WIDTH bits of the extended multiply are the exact product in either mode
    a_ext    = signed_mode ? PW'($signed(a)) : PW'(a);
    b_ext    = signed_mode ? PW'($signed(b)) : PW'(b);
    prod     = a_ext * b_ext;
    prod_ext = signed_mode ? ACC_WIDTH'($signed(prod)) : ACC_WIDTH'(prod);
    addend   = clear ? '0 : acc;
    sum      = {1'b0, addend} + {1'b0, prod_ext};
    ovf_u    = sum[ACC_WIDTH];
    ovf_s    = (addend[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != addend[ACC_WIDTH-1]);
    ovf      = signed_mode ? ovf_s : ovf_u;
`ifdef PE_SATURATE_EN
    // Signed overflow direction follows the shared operand sign; unsigned can only overflow upward
    if (ovf && signed_mode && addend[ACC_WIDTH-1])
      acc_nxt = ACC_WIDTH'(pe_min(ACC_WIDTH, signed_mode));
    else if (ovf)
      acc_nxt = ACC_WIDTH'(pe_max(ACC_WIDTH, signed_mode));
    else
      acc_nxt = sum[ACC_WIDTH-1:0];
`else
    acc_nxt = sum[ACC_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/systolic_pe.sv
// Systolic PE: forwards A/B, accumulates per tile, drains results down a column chain (PE_SATURATE_EN clamps acc).
// Latency: 1 cycle forwarding, acc and snapshot visible 1 cycle after their beat / drain_in.
// Backpressure: none; the column consumer must take one word per cycle.
module systolic_pe
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int ACC_WIDTH  = PE_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic                  clear_in,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  drain_in,
  input  logic [ACC_WIDTH-1:0]  c_in,
  input  logic                  c_valid_in,
  input  logic                  c_ovf_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  valid_out,
  output logic                  clear_out,
  output logic                  signed_out,
  output logic [ACC_WIDTH-1:0]  c_out,
  output logic                  c_valid_out,
  output logic                  c_ovf_out
);

  if (ACC_WIDTH < 2 * DATA_WIDTH || ACC_WIDTH > 64) begin : g_bad_width
    $error("systolic_pe: ACC_WIDTH must be >= 2*DATA_WIDTH and <= 64");
  end

  pe_state_t            state;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] mac_acc;
  logic                 mac_ovf;
  logic                 snap;
  logic                 beat_add;

  pe_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .signed_mode(signed_mode),
    .clear      (clear_in),
    .a          (a_in),
    .b          (b_in),
    .acc        (acc),
    .acc_nxt    (mac_acc),
    .ovf        (mac_ovf)
  );

  assign snap     = (state == PE_ACC) && drain_in;
  assign beat_add = valid_in && !clear_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out      <= '0;
      b_out      <= '0;
      valid_out  <= 1'b0;
      clear_out  <= 1'b0;
      signed_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        a_out      <= a_in;
        b_out      <= b_in;
        clear_out  <= clear_in;
        signed_out <= signed_mode;
      end
    end
  end

  // A same-cycle beat is folded into the snapshot (add) or seeds the next tile (clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (snap) begin
      acc <= (valid_in && clear_in) ? mac_acc : '0;
      ovf <= 1'b0;
    end else if (valid_in) begin
      acc <= mac_acc;
      ovf <= !clear_in && (ovf || mac_ovf);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PE_ACC;
      c_out       <= '0;
      c_valid_out <= 1'b0;
      c_ovf_out   <= 1'b0;
    end else if (snap) begin
      state       <= PE_DRAIN;
      c_out       <= beat_add ? mac_acc : acc;
      c_valid_out <= 1'b1;
      c_ovf_out   <= ovf || (beat_add && mac_ovf);
    end else if (state == PE_DRAIN) begin
      c_out       <= c_in;
      c_valid_out <= c_valid_in;
      c_ovf_out   <= c_ovf_in;
      if (!c_valid_in) state <= PE_ACC;
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Three-deep column of systolic_pe with independent operand inputs and a shared drain.
// Directed cases plus randomized beats/drains against an arithmetic reference model.
module tb_systolic_pe;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int N  = 3;

  typedef struct packed {
    logic [AW-1:0] d;
    logic          v;
    logic          o;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic drain;

  logic [DW-1:0] a_i [N];
  logic [DW-1:0] b_i [N];
  logic          v_i [N];
  logic          cl_i[N];
  logic          sg_i[N];

  logic [DW-1:0] a_o [N];
  logic [DW-1:0] b_o [N];
  logic          v_o [N];
  logic          cl_o[N];
  logic          sg_o[N];

  logic [AW-1:0] ch_d[N+1];
  logic          ch_v[N+1];
  logic          ch_f[N+1];

  assign ch_d[0] = '0;
  assign ch_v[0] = 1'b0;
  assign ch_f[0] = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_col
    systolic_pe #(
      .DATA_WIDTH(DW),
      .ACC_WIDTH (AW)
    ) u_pe (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (v_i[g]),
      .clear_in   (cl_i[g]),
      .signed_mode(sg_i[g]),
      .a_in       (a_i[g]),
      .b_in       (b_i[g]),
      .drain_in   (drain),
      .c_in       (ch_d[g]),
      .c_valid_in (ch_v[g]),
      .c_ovf_in   (ch_f[g]),
      .a_out      (a_o[g]),
      .b_out      (b_o[g]),
      .valid_out  (v_o[g]),
      .clear_out  (cl_o[g]),
      .signed_out (sg_o[g]),
      .c_out      (ch_d[g+1]),
      .c_valid_out(ch_v[g+1]),
      .c_ovf_out  (ch_f[g+1])
    );
  end

  // Reference model state
  logic [AW-1:0] m_acc[N];
  logic          m_ovf[N];
  int            m_cnt[N];
  logic [DW-1:0] m_a[N];
  logic [DW-1:0] m_b[N];
  logic          m_v[N];
  logic          m_cl[N];
  logic          m_sg[N];
  word_t         exp_q[$];
  word_t         exp_w;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_acc[k] = '0; m_ovf[k] = 1'b0; m_cnt[k] = 0;
      m_a[k] = '0; m_b[k] = '0; m_v[k] = 1'b0; m_cl[k] = 1'b0; m_sg[k] = 1'b0;
    end
    exp_q.delete();
    exp_w = '0;
  endtask

  // Apply one beat with plain integer arithmetic and explicit range limits
  task automatic model_beat(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic sg, input logic clr);
    longint p, v, s, mx, mn;
    p  = sg ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
    mx = sg ? (longint'(1) << (AW - 1)) - 1 : (longint'(1) << AW) - 1;
    mn = sg ? -(longint'(1) << (AW - 1)) : 0;
    if (clr) begin
      s = p;
      m_ovf[k] = 1'b0;
    end else begin
      v = sg ? longint'($signed(m_acc[k])) : longint'(m_acc[k]);
      s = v + p;
      if (s > mx || s < mn) begin
        m_ovf[k] = 1'b1;
`ifdef PE_SATURATE_EN
        s = (s > mx) ? mx : mn;
`endif
      end
    end
    m_acc[k] = s[AW-1:0];
  endtask

  // Row k (0 = top) stays busy in the chain for k+1 edges after an accepted drain
  task automatic model_edge();
    word_t snap[N];
    logic  took;
    took = 1'b0;
    for (int k = 0; k < N; k++) begin
      snap[k] = '0;
      if (m_cnt[k] > 0) begin
        m_cnt[k]--;
        if (v_i[k]) model_beat(k, a_i[k], b_i[k], sg_i[k], cl_i[k]);
      end else if (drain) begin
        if (v_i[k] && !cl_i[k]) model_beat(k, a_i[k], b_i[k], sg_i[k], 1'b0);
        snap[k] = '{d: m_acc[k], v: 1'b1, o: m_ovf[k]};
        m_ovf[k] = 1'b0;
        if (v_i[k] && cl_i[k]) model_beat(k, a_i[k], b_i[k], sg_i[k], 1'b1);
        else m_acc[k] = '0;
        m_cnt[k] = k + 1;
        if (k == N - 1) took = 1'b1;
      end else if (v_i[k]) begin
        model_beat(k, a_i[k], b_i[k], sg_i[k], cl_i[k]);
      end
      m_v[k] = v_i[k];
      if (v_i[k]) begin
        m_a[k] = a_i[k]; m_b[k] = b_i[k]; m_cl[k] = cl_i[k]; m_sg[k] = sg_i[k];
      end
    end
    if (took) begin
      for (int k = N - 1; k >= 0; k--) exp_q.push_back(snap[k]);
      exp_q.push_back('0);
    end
    if (exp_q.size() > 0) exp_w = exp_q.pop_front();
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      check($sformatf("a_out%0d", k), a_o[k], m_a[k]);
      check($sformatf("b_out%0d", k), b_o[k], m_b[k]);
      check($sformatf("valid_out%0d", k), v_o[k], m_v[k]);
      check($sformatf("clear_out%0d", k), cl_o[k], m_cl[k]);
      check($sformatf("signed_out%0d", k), sg_o[k], m_sg[k]);
    end
    check("c_out", ch_d[N], exp_w.d);
    check("c_valid_out", ch_v[N], exp_w.v);
    check("c_ovf_out", ch_f[N], exp_w.o);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) begin
      v_i[k] = 1'b0; cl_i[k] = 1'b0;
    end
    drain = 1'b0;
  endtask

  task automatic beat(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic sg, input logic clr);
    v_i[k] = 1'b1; a_i[k] = a; b_i[k] = b; sg_i[k] = sg; cl_i[k] = clr;
  endtask

  function automatic logic col_idle();
    logic r;
    r = 1'b1;
    for (int k = 0; k < N; k++) if (m_cnt[k] != 0) r = 1'b0;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      a_i[k] = '0; b_i[k] = '0; sg_i[k] = 1'b0;
    end
    idle_all();
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned dot product 4 x (3*5)
    beat(2, 8'd3, 8'd5, 1'b0, 1'b1); tick();
    repeat (3) begin beat(2, 8'd3, 8'd5, 1'b0, 1'b0); tick(); end
    idle_all(); drain = 1'b1; tick();
    check("dot_c", ch_d[N], 32'd60);
    check("dot_v", ch_v[N], 32'd1);
    check("dot_ovf", ch_f[N], 32'd0);
    drain = 1'b0; repeat (4) tick();

    // Signed 2 x (-2*3)
    beat(2, 8'hFE, 8'd3, 1'b1, 1'b1); tick();
    beat(2, 8'hFE, 8'd3, 1'b1, 1'b0); tick();
    idle_all(); drain = 1'b1; tick();
    check("signed_c", ch_d[N], 32'hFFF4);
    drain = 1'b0; repeat (4) tick();

    // Unsigned overflow 2 x (255*255)
    beat(2, 8'd255, 8'd255, 1'b0, 1'b1); tick();
    beat(2, 8'd255, 8'd255, 1'b0, 1'b0); tick();
    idle_all(); drain = 1'b1; tick();
`ifdef PE_SATURATE_EN
    check("ovf_c", ch_d[N], 32'hFFFF);
`else
    check("ovf_c", ch_d[N], 32'd64514);
`endif
    check("ovf_flag", ch_f[N], 32'd1);
    drain = 1'b0; repeat (4) tick();

    // Column chain 1,2,3 with drain held over a second (ignored) cycle
    beat(0, 8'd1, 8'd1, 1'b0, 1'b1); beat(1, 8'd1, 8'd2, 1'b0, 1'b1); beat(2, 8'd1, 8'd3, 1'b0, 1'b1);
    tick();
    idle_all(); drain = 1'b1; tick();
    check("chain0", ch_d[N], 32'd3);
    tick();
    check("chain1", ch_d[N], 32'd2);
    drain = 1'b0; tick();
    check("chain2", ch_d[N], 32'd1);
    check("chain2_v", ch_v[N], 32'd1);
    tick();
    check("chain_end_v", ch_v[N], 32'd0);
    drain = 1'b1; tick();
    check("rearm_v", ch_v[N], 32'd1);
    check("rearm_c", ch_d[N], 32'd0);
    drain = 1'b0; repeat (4) tick();

    // Drain overlapping the first beat of the next tile
    beat(2, 8'd3, 8'd5, 1'b0, 1'b1); tick();
    repeat (3) begin beat(2, 8'd3, 8'd5, 1'b0, 1'b0); tick(); end
    idle_all(); drain = 1'b1; beat(2, 8'd2, 8'd4, 1'b0, 1'b1); tick();
    check("overlap_old", ch_d[N], 32'd60);
    idle_all(); repeat (4) tick();
    drain = 1'b1; tick();
    check("overlap_new", ch_d[N], 32'd8);
    drain = 1'b0; repeat (4) tick();

    // Reset during the second drain cycle
    beat(2, 8'd7, 8'd1, 1'b0, 1'b1); tick();
    idle_all(); drain = 1'b1; tick();
    check("pre_rst_c", ch_d[N], 32'd7);
    drain = 1'b0;
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_a%0d", k), a_o[k], 32'd0);
      check($sformatf("rst_valid%0d", k), v_o[k], 32'd0);
      check($sformatf("rst_c%0d", k), ch_d[k+1], 32'd0);
      check($sformatf("rst_cv%0d", k), ch_v[k+1], 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    beat(2, 8'd9, 8'd1, 1'b0, 1'b1); tick();
    idle_all(); drain = 1'b1; tick();
    check("post_rst_c", ch_d[N], 32'd9);
    check("post_rst_v", ch_v[N], 32'd1);
    drain = 1'b0; repeat (4) tick();

    // Randomized beats, mode changes and column drains
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < N; k++) begin
        v_i[k]  = ($urandom_range(0, 9) < 7);
        cl_i[k] = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 7) == 0) sg_i[k] = ~sg_i[k];
        a_i[k] = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 15));
        b_i[k] = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 15));
      end
      drain = col_idle() && ($urandom_range(0, 5) == 0);
      tick();
    end
    idle_all(); repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
